// File: rtl/stream_frame_tx.sv
// Command-driven framed stream transmitter: drains exactly i_cmd_len words from a
// valid/ready source through a registered output stage, flags the last beat and pulses done.
module stream_frame_tx #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              areset,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [LEN_W-1:0]  i_cmd_len,
   input  logic              i_s_valid,
   output logic              o_s_ready,
   input  logic [DATA_W-1:0] i_s_data,
   output logic              o_m_valid,
   input  logic              i_m_ready,
   output logic [DATA_W-1:0] o_m_data,
   output logic              o_m_last,
   output logic              o_busy,
   output logic              o_done,
   output logic [LEN_W-1:0]  o_beat_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] acc;
   logic             cmd_hs;
   logic             in_hs;
   logic             out_hs;
   logic             acc_full;
   logic             last_acc;
   logic             zero_len;
   logic             frame_end;

   assign o_cmd_ready = (state == ST_IDLE);
   assign o_busy      = (state == ST_RUN) | (state == ST_DONE);
   assign acc_full    = (acc == len);
   assign last_acc    = (acc == (len - LEN_W'(1)));
   assign zero_len    = (len == {LEN_W{1'b0}});

   // Pull only while words are still owed and the output register is free or draining;
   // never pull on a reset edge, where the word would be dropped.
   assign o_s_ready = (state == ST_RUN) & ~acc_full & (~o_m_valid | i_m_ready) & ~areset;

   assign cmd_hs = i_cmd_valid & o_cmd_ready;
   assign in_hs  = i_s_valid & o_s_ready;
   assign out_hs = o_m_valid & i_m_ready;

   // Zero-length frames spend one RUN cycle so done lands N+2 cycles after the command.
   assign frame_end = (state == ST_RUN) & ((out_hs & o_m_last) | zero_len);

   // Control FSM, output register and beat counters.
   always_ff @(posedge clk) begin
      if (areset) begin
         state      <= ST_IDLE;
         len        <= {LEN_W{1'b0}};
         acc        <= {LEN_W{1'b0}};
         o_m_valid  <= 1'b0;
         o_m_data   <= {DATA_W{1'b0}};
         o_m_last   <= 1'b0;
         o_done     <= 1'b0;
         o_beat_cnt <= {LEN_W{1'b0}};
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_hs) begin
                  len        <= i_cmd_len;
                  acc        <= {LEN_W{1'b0}};
                  o_beat_cnt <= {LEN_W{1'b0}};
                  state      <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (in_hs) begin
                  o_m_data  <= i_s_data;
                  o_m_valid <= 1'b1;
                  o_m_last  <= last_acc;
                  acc       <= acc + LEN_W'(1);
               end else if (out_hs) begin
                  o_m_valid <= 1'b0;
                  o_m_last  <= 1'b0;
               end
               if (out_hs) begin
                  o_beat_cnt <= o_beat_cnt + LEN_W'(1);
               end
               if (frame_end) begin
                  state  <= ST_DONE;
                  o_done <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_frame_tx.sv
// Directed bench for stream_frame_tx: a queue-backed source, a log of output beats,
// and one task per scenario with hand-computed expectations.
module tb_stream_frame_tx;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 16;

   logic              clk = 1'b0;
   logic              areset = 1'b0;
   logic              i_cmd_valid = 1'b0;
   logic              o_cmd_ready;
   logic [LEN_W-1:0]  i_cmd_len = '0;
   logic              i_s_valid = 1'b0;
   logic              o_s_ready;
   logic [DATA_W-1:0] i_s_data = '0;
   logic              o_m_valid;
   logic              i_m_ready = 1'b0;
   logic [DATA_W-1:0] o_m_data;
   logic              o_m_last;
   logic              o_busy;
   logic              o_done;
   logic [LEN_W-1:0]  o_beat_cnt;

   logic [DATA_W-1:0] src_q[$];
   logic [DATA_W-1:0] out_d[$];
   logic              out_l[$];
   int done_cnt, cmd_cnt, cmd_cyc, cyc;
   int n_chk = 0;
   int n_fail = 0;

   stream_frame_tx #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .areset(areset),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_len(i_cmd_len),
      .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data),
      .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_data(o_m_data), .o_m_last(o_m_last),
      .o_busy(o_busy), .o_done(o_done), .o_beat_cnt(o_beat_cnt)
   );

   always #5 clk = ~clk;

   task automatic drive_src();
      i_s_valid = (src_q.size() > 0);
      i_s_data  = (src_q.size() > 0) ? src_q[0] : '0;
   endtask

   task automatic clear_log();
      out_d.delete();
      out_l.delete();
      done_cnt = 0;
      cmd_cnt  = 0;
      cmd_cyc  = -1;
      cyc      = 0;
   endtask

   // One clock: sample handshakes before the edge, then pop the source and settle.
   task automatic step();
      bit ih, oh, ch;
      #1;
      ih = i_s_valid & o_s_ready;
      oh = o_m_valid & i_m_ready & ~areset;
      ch = i_cmd_valid & o_cmd_ready & ~areset;
      if (oh) begin
         out_d.push_back(o_m_data);
         out_l.push_back(o_m_last);
      end
      if (ch) begin
         cmd_cnt++;
         cmd_cyc = cyc;
      end
      if (o_done) done_cnt++;
      @(posedge clk);
      #1;
      if (ih) void'(src_q.pop_front());
      cyc++;
      drive_src();
      #1;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      step();
      step();
      areset = 1'b0;
      n_chk++; if (o_m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_m_valid); end
      n_chk++; if (o_m_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", o_m_last); end
      n_chk++; if (o_m_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", o_m_data); end
      n_chk++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o_done); end
      n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      n_chk++; if (o_beat_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", o_beat_cnt); end
      n_chk++; if (o_s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", o_s_ready); end
      n_chk++; if (o_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", o_cmd_ready); end
   endtask

   task automatic test_basic();
      bit ev, el, ed;
      src_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      drive_src();
      i_m_ready = 1'b1;
      i_cmd_len = 16'd4;
      i_cmd_valid = 1'b1;
      clear_log();
      step();
      i_cmd_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         ev = (k >= 2 && k <= 5);
         el = (k == 5);
         ed = (k == 6);
         n_chk++; if (o_m_valid !== ev) begin n_fail++; $display("FAIL basic_valid c%0d: got %b want %b", k, o_m_valid, ev); end
         n_chk++; if (o_m_last !== el) begin n_fail++; $display("FAIL basic_last c%0d: got %b want %b", k, o_m_last, el); end
         n_chk++; if (o_done !== ed) begin n_fail++; $display("FAIL basic_done c%0d: got %b want %b", k, o_done, ed); end
         if (ev) begin
            n_chk++; if (o_m_data !== 32'hA0 + 32'(k - 2)) begin n_fail++; $display("FAIL basic_data c%0d: got %h want %h", k, o_m_data, 32'hA0 + 32'(k - 2)); end
         end
         step();
      end
      n_chk++; if (o_beat_cnt !== 16'd4) begin n_fail++; $display("FAIL basic_cnt: got %0d want 4", o_beat_cnt); end
      n_chk++; if (out_d.size() != 4) begin n_fail++; $display("FAIL basic_beats: got %0d want 4", out_d.size()); end
   endtask

   task automatic test_stall();
      logic [DATA_W-1:0] exp_d[$];
      logic              exp_l[$];
      exp_d = '{32'hB0, 32'hB1, 32'hB2};
      exp_l = '{1'b0, 1'b0, 1'b1};
      src_q = '{32'hB0, 32'hB1, 32'hB2};
      drive_src();
      i_cmd_len = 16'd3;
      i_cmd_valid = 1'b1;
      clear_log();
      step();
      i_cmd_valid = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         i_m_ready = !(k >= 3 && k <= 5);
         #1;
         if (k >= 3 && k <= 5) begin
            n_chk++; if (o_m_data !== 32'hB1 || o_m_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold c%0d: got %h/%b want b1/1", k, o_m_data, o_m_valid); end
            n_chk++; if (o_s_ready !== 1'b0) begin n_fail++; $display("FAIL stall_s_ready c%0d: got %b want 0", k, o_s_ready); end
         end
         step();
      end
      n_chk++; if (out_d.size() != 3) begin n_fail++; $display("FAIL stall_beats: got %0d want 3", out_d.size()); end
      for (int i = 0; i < out_d.size() && i < 3; i++) begin
         n_chk++; if (out_d[i] !== exp_d[i] || out_l[i] !== exp_l[i]) begin n_fail++; $display("FAIL stall_beat%0d: got %h/%b want %h/%b", i, out_d[i], out_l[i], exp_d[i], exp_l[i]); end
      end
      n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
      n_chk++; if (o_beat_cnt !== 16'd3) begin n_fail++; $display("FAIL stall_cnt: got %0d want 3", o_beat_cnt); end
   endtask

   task automatic test_over_read();
      src_q = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5};
      drive_src();
      i_m_ready = 1'b1;
      i_cmd_len = 16'd2;
      i_cmd_valid = 1'b1;
      clear_log();
      step();
      i_cmd_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 3) begin
            n_chk++; if (o_s_ready !== 1'b0 || i_s_valid !== 1'b1) begin n_fail++; $display("FAIL over_s_ready: got %b want 0", o_s_ready); end
         end
         step();
      end
      n_chk++; if (src_q.size() != 4) begin n_fail++; $display("FAIL over_left: got %0d want 4", src_q.size()); end
      n_chk++; if (out_d.size() != 2) begin n_fail++; $display("FAIL over_beats1: got %0d want 2", out_d.size()); end
      for (int i = 0; i < out_d.size() && i < 2; i++) begin
         n_chk++; if (out_d[i] !== 32'hC0 + 32'(i) || out_l[i] !== (i == 1)) begin n_fail++; $display("FAIL over_beat%0d: got %h/%b want %h/%b", i, out_d[i], out_l[i], 32'hC0 + 32'(i), (i == 1)); end
      end
      i_cmd_len = 16'd4;
      i_cmd_valid = 1'b1;
      clear_log();
      step();
      i_cmd_valid = 1'b0;
      for (int k = 1; k <= 10; k++) step();
      n_chk++; if (src_q.size() != 0) begin n_fail++; $display("FAIL over_drained: got %0d want 0", src_q.size()); end
      n_chk++; if (out_d.size() != 4) begin n_fail++; $display("FAIL over_beats2: got %0d want 4", out_d.size()); end
      for (int i = 0; i < out_d.size() && i < 4; i++) begin
         n_chk++; if (out_d[i] !== 32'hC2 + 32'(i) || out_l[i] !== (i == 3)) begin n_fail++; $display("FAIL over_beat2_%0d: got %h/%b want %h/%b", i, out_d[i], out_l[i], 32'hC2 + 32'(i), (i == 3)); end
      end
      n_chk++; if (o_beat_cnt !== 16'd4) begin n_fail++; $display("FAIL over_cnt: got %0d want 4", o_beat_cnt); end
   endtask

   task automatic test_zero_len();
      src_q = '{32'hD0};
      drive_src();
      i_cmd_len = 16'd0;
      i_cmd_valid = 1'b1;
      clear_log();
      step();
      i_cmd_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         n_chk++; if (o_m_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid c%0d: got %b want 0", k, o_m_valid); end
         n_chk++; if (o_done !== (k == 2)) begin n_fail++; $display("FAIL zero_done c%0d: got %b want %b", k, o_done, (k == 2)); end
         n_chk++; if (o_s_ready !== 1'b0) begin n_fail++; $display("FAIL zero_s_ready c%0d: got %b want 0", k, o_s_ready); end
         step();
      end
      n_chk++; if (o_beat_cnt !== 16'd0) begin n_fail++; $display("FAIL zero_cnt: got %0d want 0", o_beat_cnt); end
      n_chk++; if (src_q.size() != 1) begin n_fail++; $display("FAIL zero_left: got %0d want 1", src_q.size()); end
      src_q.delete();
      drive_src();
   endtask

   task automatic test_back_to_back();
      src_q = '{32'hE0, 32'hE1, 32'hE2};
      drive_src();
      i_cmd_len = 16'd2;
      i_cmd_valid = 1'b1;
      clear_log();
      step();
      i_cmd_len = 16'd1;
      for (int k = 1; k <= 10; k++) begin
         if (k <= 4) begin
            n_chk++; if (o_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_cmd_ready c%0d: got %b want 0", k, o_cmd_ready); end
         end
         if (k == 5) begin
            n_chk++; if (o_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle c5: got %b want 1", o_cmd_ready); end
         end
         step();
         if (cmd_cnt >= 2) i_cmd_valid = 1'b0;
      end
      i_cmd_valid = 1'b0;
      n_chk++; if (cmd_cnt != 2 || cmd_cyc != 5) begin n_fail++; $display("FAIL b2b_accept: got cnt %0d cyc %0d want 2/5", cmd_cnt, cmd_cyc); end
      n_chk++; if (out_d.size() != 3) begin n_fail++; $display("FAIL b2b_beats: got %0d want 3", out_d.size()); end
      for (int i = 0; i < out_d.size() && i < 3; i++) begin
         n_chk++; if (out_d[i] !== 32'hE0 + 32'(i) || out_l[i] !== (i != 0)) begin n_fail++; $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", i, out_d[i], out_l[i], 32'hE0 + 32'(i), (i != 0)); end
      end
      n_chk++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done: got %0d want 2", done_cnt); end
   endtask

   task automatic test_reset_mid();
      src_q = '{32'hF0, 32'hF1, 32'hF2, 32'hF3, 32'hF4};
      drive_src();
      i_m_ready = 1'b1;
      i_cmd_len = 16'd5;
      i_cmd_valid = 1'b1;
      clear_log();
      step();
      i_cmd_valid = 1'b0;
      for (int k = 1; k <= 3; k++) step();
      areset = 1'b1;
      i_m_ready = 1'b0;
      step();
      areset = 1'b0;
      i_m_ready = 1'b1;
      n_chk++; if (o_m_valid !== 1'b0 || o_m_last !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b/%b want 0/0", o_m_valid, o_m_last); end
      n_chk++; if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got %b/%b want 1/0", o_cmd_ready, o_busy); end
      n_chk++; if (out_d.size() != 2) begin n_fail++; $display("FAIL rst_mid_beats: got %0d want 2", out_d.size()); end
      n_chk++; if (src_q.size() != 2) begin n_fail++; $display("FAIL rst_mid_left: got %0d want 2", src_q.size()); end
      for (int k = 0; k < 4; k++) step();
      n_chk++; if (done_cnt != 0) begin n_fail++; $display("FAIL rst_mid_done: got %0d want 0", done_cnt); end
      src_q = '{32'h5A};
      drive_src();
      i_cmd_len = 16'd1;
      i_cmd_valid = 1'b1;
      clear_log();
      step();
      i_cmd_valid = 1'b0;
      for (int k = 0; k < 6; k++) step();
      n_chk++; if (out_d.size() != 1) begin n_fail++; $display("FAIL rst_new_beats: got %0d want 1", out_d.size()); end
      else begin
         n_chk++; if (out_d[0] !== 32'h5A || out_l[0] !== 1'b1) begin n_fail++; $display("FAIL rst_new_beat: got %h/%b want 5a/1", out_d[0], out_l[0]); end
      end
      n_chk++; if (done_cnt != 1 || o_beat_cnt !== 16'd1) begin n_fail++; $display("FAIL rst_new_done: got %0d/%0d want 1/1", done_cnt, o_beat_cnt); end
   endtask

   initial begin
      clear_log();
      test_reset();
      test_basic();
      test_stall();
      test_over_read();
      test_zero_len();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
